// File: rtl/k_and_s_pkg.sv
// Shared definitions for the K-and-S instruction-side datapath: decoded
// instruction type, ISA opcodes and instruction field positions.
package k_and_s_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 5;
  localparam int unsigned DATA_W_DEFAULT = 16;

  // Instruction field positions
  localparam int unsigned OPC_MSB      = 15;
  localparam int unsigned OPC_LSB      = 8;
  localparam int unsigned MEM_ADDR_LSB = 0;

  typedef enum logic [3:0] {
    I_NOP,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNZERO,
    I_BNNEG,
    I_BNOV,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_HALT
  } decoded_instruction_type;

  // ISA opcodes, ir[OPC_MSB:OPC_LSB]
  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_BRANCH = 8'h01;
  localparam logic [7:0] OPC_BZERO  = 8'h02;
  localparam logic [7:0] OPC_BNEG   = 8'h03;
  localparam logic [7:0] OPC_BOV    = 8'h05;
  localparam logic [7:0] OPC_BNZERO = 8'h0A;
  localparam logic [7:0] OPC_BNNEG  = 8'h0B;
  localparam logic [7:0] OPC_BNOV   = 8'h0D;
  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

  // Three-operand ALU instructions share one register-field layout
  function automatic logic is_alu_op(decoded_instruction_type ins);
    return (ins == I_ADD) || (ins == I_SUB) || (ins == I_AND) || (ins == I_OR);
  endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Bus between control_unit (master) and fetch_decode_unit (slave): control
// strobes, RAM read data, raw ALU flags and the decoded/registered results.
interface fetch_decode_unit_if #(
  parameter int unsigned ADDR_W = k_and_s_pkg::ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = k_and_s_pkg::DATA_W_DEFAULT
);
  import k_and_s_pkg::*;

  logic                    pc_enable;
  logic                    branch;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    flags_reg_enable;
  logic [DATA_W-1:0]       ram_data;
  logic                    alu_zero;
  logic                    alu_neg;
  logic                    alu_uov;
  logic                    alu_sov;

  logic [ADDR_W-1:0]       ram_addr;
  decoded_instruction_type decoded_instruction;
  logic [1:0]              a_addr;
  logic [1:0]              b_addr;
  logic [1:0]              c_addr;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic [ADDR_W-1:0]       pc_out;
  logic                    illegal_opcode;

  modport master (
    output pc_enable, branch, ir_enable, addr_sel, flags_reg_enable, ram_data,
           alu_zero, alu_neg, alu_uov, alu_sov,
    input  ram_addr, decoded_instruction, a_addr, b_addr, c_addr, zero_op, neg_op,
           unsigned_overflow, signed_overflow, pc_out, illegal_opcode
  );

  modport slave (
    input  pc_enable, branch, ir_enable, addr_sel, flags_reg_enable, ram_data,
           alu_zero, alu_neg, alu_uov, alu_sov,
    output ram_addr, decoded_instruction, a_addr, b_addr, c_addr, zero_op, neg_op,
           unsigned_overflow, signed_overflow, pc_out, illegal_opcode
  );

endinterface

// File: rtl/instruction_decoder.sv
// Combinational decode of the instruction register: opcode lookup plus the
// register-file index fields, whose layout depends on the instruction class.
module instruction_decoder
  import k_and_s_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0]       ir,
  output decoded_instruction_type decoded_instruction,
  output logic [1:0]              a_addr,
  output logic [1:0]              b_addr,
  output logic [1:0]              c_addr,
  output logic                    illegal_opcode
);

  logic [7:0] opcode;
  assign opcode = ir[OPC_MSB:OPC_LSB];

  // ir[7] carries no field in this ISA
  logic unused_ir_bit;
  assign unused_ir_bit = ir[7];

  // Opcode lookup; unknown opcodes execute as NOP and are flagged
  always_comb begin
    decoded_instruction = I_NOP;
    illegal_opcode      = 1'b0;
    case (opcode)
      OPC_NOP:    decoded_instruction = I_NOP;
      OPC_BRANCH: decoded_instruction = I_BRANCH;
      OPC_BZERO:  decoded_instruction = I_BZERO;
      OPC_BNEG:   decoded_instruction = I_BNEG;
      OPC_BOV:    decoded_instruction = I_BOV;
      OPC_BNZERO: decoded_instruction = I_BNZERO;
      OPC_BNNEG:  decoded_instruction = I_BNNEG;
      OPC_BNOV:   decoded_instruction = I_BNOV;
      OPC_LOAD:   decoded_instruction = I_LOAD;
      OPC_STORE:  decoded_instruction = I_STORE;
      OPC_MOVE:   decoded_instruction = I_MOVE;
      OPC_ADD:    decoded_instruction = I_ADD;
      OPC_SUB:    decoded_instruction = I_SUB;
      OPC_AND:    decoded_instruction = I_AND;
      OPC_OR:     decoded_instruction = I_OR;
      OPC_HALT:   decoded_instruction = I_HALT;
      default:    illegal_opcode      = 1'b1;
    endcase
  end

  // Register-index fields per instruction class; everything else reads zero
  always_comb begin
    a_addr = 2'd0;
    b_addr = 2'd0;
    c_addr = 2'd0;
    if (is_alu_op(decoded_instruction)) begin
      c_addr = ir[5:4];
      a_addr = ir[3:2];
      b_addr = ir[1:0];
    end else if (decoded_instruction == I_MOVE) begin
      c_addr = ir[3:2];
      a_addr = ir[1:0];
    end else if (decoded_instruction == I_LOAD) begin
      c_addr = ir[6:5];
    end else if (decoded_instruction == I_STORE) begin
      a_addr = ir[6:5];
    end
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction-side datapath: PC, IR and flags registers, RAM address mux and
// the instruction decoder feeding control_unit.
module fetch_decode_unit
  import k_and_s_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  fetch_decode_unit_if.slave bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [3:0]        flags_q;

  decoded_instruction_type dec_ins;
  logic [1:0]              dec_a;
  logic [1:0]              dec_b;
  logic [1:0]              dec_c;
  logic                    dec_illegal;

  // PC: sequential increment wraps naturally at 2^ADDR_W; branch takes the IR target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else if (bus.pc_enable) begin
      pc_q <= bus.branch ? ir_q[MEM_ADDR_LSB +: ADDR_W] : pc_q + 1'b1;
    end
  end

  // IR: ram_data was addressed by the pre-edge PC, so fetch with PC advance is safe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
    end else if (bus.ir_enable) begin
      ir_q <= bus.ram_data;
    end
  end

  // Flags: capture raw ALU flags on request, independent of the IR load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (bus.flags_reg_enable) begin
      flags_q <= {bus.alu_zero, bus.alu_neg, bus.alu_uov, bus.alu_sov};
    end
  end

  instruction_decoder #(
    .DATA_W (DATA_W)
  ) u_decoder (
    .ir                  (ir_q),
    .decoded_instruction (dec_ins),
    .a_addr              (dec_a),
    .b_addr              (dec_b),
    .c_addr              (dec_c),
    .illegal_opcode      (dec_illegal)
  );

  assign bus.ram_addr            = bus.addr_sel ? ir_q[MEM_ADDR_LSB +: ADDR_W] : pc_q;
  assign bus.pc_out              = pc_q;
  assign bus.decoded_instruction = dec_ins;
  assign bus.a_addr              = dec_a;
  assign bus.b_addr              = dec_b;
  assign bus.c_addr              = dec_c;
  assign bus.illegal_opcode      = dec_illegal;
  assign bus.zero_op             = flags_q[3];
  assign bus.neg_op              = flags_q[2];
  assign bus.unsigned_overflow   = flags_q[1];
  assign bus.signed_overflow     = flags_q[0];

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
Instruction-side datapath stage directly upstream of control_unit. Holds the program counter (PC), instruction register (IR) and flags register, and drives the RAM address mux. Decodes the registered instruction into decoded_instruction, the register-file indices and the flag outputs that control_unit consumes. It acts on control_unit's branch/pc_enable/ir_enable/addr_sel/flags_reg_enable strobes.

Parameters:
ADDR_W, 5, RAM word-address width; PC width.
DATA_W, 16, instruction/RAM data width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
pc_enable  in  1  update PC this cycle.
branch  in  1  PC update source select: 1 = IR target field, 0 = PC+1.
ir_enable  in  1  load IR from ram_data this cycle.
addr_sel  in  1  ram_addr source: 1 = IR mem field, 0 = PC.
flags_reg_enable  in  1  capture ALU flags this cycle.
ram_data  in  DATA_W  RAM read data.
alu_zero, alu_neg, alu_uov, alu_sov  in  1 each  raw ALU flags.
ram_addr  out  ADDR_W  RAM address.
decoded_instruction  out  decoded_instruction_type  decoded IR opcode.
a_addr, b_addr, c_addr  out  2 each  register-file indices.
zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags.
pc_out  out  ADDR_W  current PC (debug).
illegal_opcode  out  1  IR opcode is not in the ISA table.

Behaviour:
- Reset (async, rst=1): pc=0, ir=16'h0000, all four flags=0, taking effect immediately mid-cycle. Outputs while in reset: decoded_instruction=I_NOP, ram_addr=0, illegal_opcode=0, a/b/c_addr=0.
- PC: on a rising edge with pc_enable=1:
  - branch=0: pc <= pc+1, modulo 2^ADDR_W (31 -> 0).
  - branch=1: pc <= ir[ADDR_W-1:0].
  - branch with pc_enable=0 is ignored; pc holds.
- IR: on a rising edge with ir_enable=1, ir <= ram_data. Otherwise ir holds.
- ir_enable and pc_enable in the same cycle (fetch): IR captures the data for the old PC and PC advances. There is no hazard because ram_data was addressed by the old pc.
- RAM read is synchronous: ram_data is valid one cycle after ram_addr is presented.
- ram_addr = addr_sel ? ir[ADDR_W-1:0] : pc. This is combinational and glitch-tolerant.
- Flags: on a rising edge with flags_reg_enable=1, {zero_op, neg_op, unsigned_overflow, signed_overflow} <= {alu_zero, alu_neg, alu_uov, alu_sov}. Otherwise the flags hold.
- Decode is combinational from the registered IR only; latency from the IR load edge to decoded outputs is 0 cycles.
- Opcode ir[15:8] map:
  - 8'h00 -> I_NOP.
  - 8'h01 -> I_BRANCH, 8'h02 -> I_BZERO, 8'h03 -> I_BNEG, 8'h05 -> I_BOV.
  - 8'h0A -> I_BNZERO, 8'h0B -> I_BNNEG, 8'h0D -> I_BNOV.
  - 8'h81 -> I_LOAD, 8'h82 -> I_STORE, 8'h91 -> I_MOVE.
  - 8'hA1 -> I_ADD, 8'hA2 -> I_SUB, 8'hA3 -> I_AND, 8'hA4 -> I_OR.
  - 8'hFF -> I_HALT.
  - Any other opcode -> I_NOP with illegal_opcode=1.
- Register fields:
  - ALU ops: c_addr=ir[5:4], a_addr=ir[3:2], b_addr=ir[1:0].
  - MOVE: c_addr=ir[3:2] (dest), a_addr=ir[1:0] (src), b_addr=0.
  - LOAD: c_addr=ir[6:5]. STORE: a_addr=ir[6:5]. Memory address is ir[4:0].
  - Branches and NOP/HALT: all indices 0.
- Simultaneous ir_enable and flags_reg_enable: both registers update independently.

Decomposition:
- k_and_s_pkg gains:
  - the decoded_instruction_type enum, with I_NOP added;
  - 8-bit opcode localparams for each instruction;
  - field-position localparams (OPC_MSB=15, OPC_LSB=8, MEM_ADDR_LSB=0);
  - the ADDR_W default.
- One combinational sub-module, instruction_decoder: IR in; decoded_instruction, a/b/c_addr and illegal_opcode out.
- PC, IR, flags and the address mux stay in fetch_decode_unit.

Test Plan:
- Reset: assert rst mid-cycle with pc=7 -> pc_out=0, ram_addr=0 and decoded_instruction=I_NOP immediately, before the next edge.
- Fetch: RAM[0]=16'hA1_1B; pulse ir_enable+pc_enable one cycle after ram_addr=0 -> pc_out=1, decoded_instruction=I_ADD, c_addr=1, a_addr=2, b_addr=3.
- Branch: IR=16'h0113, then pc_enable=1, branch=1 -> pc_out=19. Repeat with branch=1, pc_enable=0 -> pc_out unchanged.
- Wrap: pc=31, pc_enable=1, branch=0 -> pc_out=0.
- Flags: alu_{zero,neg,uov,sov}=1,0,1,0 with flags_reg_enable=1 -> outputs 1,0,1,0 after the edge. Then change the ALU inputs with enable=0 -> outputs hold.
- Address mux/illegal: IR=16'h8245 with addr_sel=1 -> ram_addr=5, I_STORE, a_addr=2. IR=16'h7700 -> I_NOP with illegal_opcode=1.
